time_keeper: RTL and testbench
==============================

// Module: time_keeper
// PURPOSE
//  Running BCD day/hour/min/sec counter. It is the consumer of the time-set digit bus.
//  While SET=1 it mirrors and validates the set digits S*. When SET falls it resumes
//  counting from the loaded value, driven by an internal 1 Hz tick derived from CLK.
//  Its outputs feed the seven-segment display path and alarm/compare logic.
// PARAMETERS
//  TICK_DIV  50_000_000  CLK cycles per counted second (benches use 4)
//  CNT_W     26          prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  CLK        in   1  system clock (the only clock)
//  RST        in   1  synchronous active-high reset
//  SET        in   1  1 = set mode (mirror S* digits, counting frozen)
//  SSEC0/1    in   4  set seconds, BCD ones/tens
//  SMIN0/1    in   4  set minutes, BCD ones/tens
//  SHOUR0/1   in   4  set hours, BCD ones/tens
//  SDAY0/1    in   4  set day, BCD ones/tens
//  SEC0/1     out  4  running seconds, BCD
//  MIN0/1     out  4  running minutes, BCD
//  HOUR0/1    out  4  running hours, BCD
//  DAY0/1     out  4  running day, BCD
//  TICK       out  1  one-cycle pulse on each counted second
//  DAY_ROLL   out  1  one-cycle pulse when day wraps 31 -> 01
//  LOAD_ERR   out  1  high while any mirrored set field is out of range
// BEHAVIOUR
//  Clock/reset: one clock CLK; reset RST is synchronous and active-high.
//  Reset (highest priority, including over SET): DAY=01, HOUR=00, MIN=00, SEC=00;
//   prescaler=0; TICK=0, DAY_ROLL=0, LOAD_ERR=0.
//  Prescaler: counts 0..TICK_DIV-1 while SET=0. On the cycle it wraps from TICK_DIV-1
//   to 0, TICK=1 for that cycle only. While SET=1 the prescaler is held at 0 and TICK=0.
//  Set mode (SET=1): every cycle each field register loads its S* pair (1-cycle latency).
//   Each field is validated independently:
//   - digit >9 in any position, sec/min >59, hour >23, or day 00 or >31 makes the field invalid.
//   - An invalid field loads its minimum instead (sec/min/hour 00, day 01).
//   - LOAD_ERR is registered; it is 1 on the cycle after any field is invalid, else 0.
//   LOAD_ERR is forced to 0 one cycle after SET=0.
//  Run mode (SET=0): on a TICK cycle the fields update in that same cycle.
//   - SEC increments BCD; 59 -> 00 carries into MIN.
//   - MIN 59 -> 00 carries into HOUR.
//   - HOUR 23 -> 00 carries into DAY.
//   - DAY 31 -> 01; DAY_ROLL=1 in the same cycle the outputs show 01.
//   - The full cascade resolves in one cycle; no intermediate values are ever visible.
//   - Days per month are not modelled: the day always wraps at 31.
//  SET 1->0: the counter holds the last mirrored value. The first increment occurs
//   exactly TICK_DIV cycles after the first cycle with SET=0.
//  SET 0->1 on a would-be TICK cycle: SET wins, no increment, TICK=0.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING (TICK_DIV=4)
//  1) Reset 3 cycles, release -> 01 00:00:00; TICK every 4th cycle; SEC0 1,2,3...
//  2) SET=1 with 01 23:59:58, then SET=0 -> after 2 TICKs 02 00:00:00, DAY_ROLL=0
//  3) Load 31 23:59:59, release -> next TICK gives 01 00:00:00, DAY_ROLL=1 same cycle
//  4) SET=1, SHOUR=2,4, SMIN=3,0 -> LOAD_ERR=1, HOUR=00, MIN=30; then SHOUR=1,2 -> LOAD_ERR=0
//  5) SET pulsed mid-prescale (count 2) -> no TICK during SET; first TICK 4 cycles after release
//  6) RST=1 while SET=1 with day 15 -> next cycle 01 00:00:00, LOAD_ERR=0

Source files
------------

// File: rtl/time_keeper_if.sv
// Time-set digit bus and running time outputs of the time keeper.
// The master drives the set digits and the keeper drives the running time.
interface time_keeper_if;
  logic       SET;
  logic [3:0] SSEC0;
  logic [3:0] SSEC1;
  logic [3:0] SMIN0;
  logic [3:0] SMIN1;
  logic [3:0] SHOUR0;
  logic [3:0] SHOUR1;
  logic [3:0] SDAY0;
  logic [3:0] SDAY1;
  logic [3:0] SEC0;
  logic [3:0] SEC1;
  logic [3:0] MIN0;
  logic [3:0] MIN1;
  logic [3:0] HOUR0;
  logic [3:0] HOUR1;
  logic [3:0] DAY0;
  logic [3:0] DAY1;
  logic       TICK;
  logic       DAY_ROLL;
  logic       LOAD_ERR;

  modport master (
    output SET,
    output SSEC0, SSEC1,
    output SMIN0, SMIN1,
    output SHOUR0, SHOUR1,
    output SDAY0, SDAY1,
    input  SEC0, SEC1,
    input  MIN0, MIN1,
    input  HOUR0, HOUR1,
    input  DAY0, DAY1,
    input  TICK,
    input  DAY_ROLL,
    input  LOAD_ERR
  );

  modport slave (
    input  SET,
    input  SSEC0, SSEC1,
    input  SMIN0, SMIN1,
    input  SHOUR0, SHOUR1,
    input  SDAY0, SDAY1,
    output SEC0, SEC1,
    output MIN0, MIN1,
    output HOUR0, HOUR1,
    output DAY0, DAY1,
    output TICK,
    output DAY_ROLL,
    output LOAD_ERR
  );
endinterface

// File: rtl/time_keeper.sv
// Running BCD day/hour/min/sec counter with a 1 Hz prescaler.
// Set mode mirrors and validates the set digits; run mode counts.
module time_keeper #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic         CLK,
  input  logic         RST,
  time_keeper_if.slave tk
);

  logic [CNT_W-1:0] pre;
  logic             wrap;

  logic [3:0] sec0, sec1;
  logic [3:0] min0, min1;
  logic [3:0] hour0, hour1;
  logic [3:0] day0, day1;

  logic tick_q;
  logic roll_q;
  logic err_q;

  logic sec_ok, min_ok;
  logic hour_ok, day_ok;

  logic [3:0] n_sec0, n_sec1;
  logic [3:0] n_min0, n_min1;
  logic [3:0] n_hour0, n_hour1;
  logic [3:0] n_day0, n_day1;
  logic       c_min, c_hour;
  logic       c_day, c_roll;

  function automatic logic fld_ok(
    input logic [3:0] t,
    input logic [3:0] o,
    input int         lo,
    input int         hi
  );
    int v;
    v = int'(t) * 10 + int'(o);
    return (t <= 4'd9) && (o <= 4'd9)
        && (v >= lo) && (v <= hi);
  endfunction

  assign wrap = (pre == CNT_W'(TICK_DIV - 1));

  always_comb begin
    sec_ok  = fld_ok(tk.SSEC1, tk.SSEC0, 0, 59);
    min_ok  = fld_ok(tk.SMIN1, tk.SMIN0, 0, 59);
    hour_ok = fld_ok(tk.SHOUR1, tk.SHOUR0, 0, 23);
    day_ok  = fld_ok(tk.SDAY1, tk.SDAY0, 1, 31);
  end

  // Whole carry chain is resolved here so a tick updates every field at once
  always_comb begin
    n_sec0  = sec0;
    n_sec1  = sec1;
    n_min0  = min0;
    n_min1  = min1;
    n_hour0 = hour0;
    n_hour1 = hour1;
    n_day0  = day0;
    n_day1  = day1;
    c_min   = 1'b0;
    c_hour  = 1'b0;
    c_day   = 1'b0;
    c_roll  = 1'b0;

    if (sec0 == 4'd9) begin
      n_sec0 = 4'd0;
      if (sec1 == 4'd5) begin
        n_sec1 = 4'd0;
        c_min  = 1'b1;
      end else begin
        n_sec1 = sec1 + 4'd1;
      end
    end else begin
      n_sec0 = sec0 + 4'd1;
    end

    if (c_min) begin
      if (min0 == 4'd9) begin
        n_min0 = 4'd0;
        if (min1 == 4'd5) begin
          n_min1 = 4'd0;
          c_hour = 1'b1;
        end else begin
          n_min1 = min1 + 4'd1;
        end
      end else begin
        n_min0 = min0 + 4'd1;
      end
    end

    if (c_hour) begin
      if (hour1 == 4'd2 && hour0 == 4'd3) begin
        n_hour1 = 4'd0;
        n_hour0 = 4'd0;
        c_day   = 1'b1;
      end else if (hour0 == 4'd9) begin
        n_hour0 = 4'd0;
        n_hour1 = hour1 + 4'd1;
      end else begin
        n_hour0 = hour0 + 4'd1;
      end
    end

    if (c_day) begin
      if (day1 == 4'd3 && day0 == 4'd1) begin
        n_day1 = 4'd0;
        n_day0 = 4'd1;
        c_roll = 1'b1;
      end else if (day0 == 4'd9) begin
        n_day0 = 4'd0;
        n_day1 = day1 + 4'd1;
      end else begin
        n_day0 = day0 + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre    <= '0;
      sec0   <= 4'd0;
      sec1   <= 4'd0;
      min0   <= 4'd0;
      min1   <= 4'd0;
      hour0  <= 4'd0;
      hour1  <= 4'd0;
      day0   <= 4'd1;
      day1   <= 4'd0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (tk.SET) begin
      pre    <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
      sec0   <= sec_ok ? tk.SSEC0 : 4'd0;
      sec1   <= sec_ok ? tk.SSEC1 : 4'd0;
      min0   <= min_ok ? tk.SMIN0 : 4'd0;
      min1   <= min_ok ? tk.SMIN1 : 4'd0;
      hour0  <= hour_ok ? tk.SHOUR0 : 4'd0;
      hour1  <= hour_ok ? tk.SHOUR1 : 4'd0;
      day0   <= day_ok ? tk.SDAY0 : 4'd1;
      day1   <= day_ok ? tk.SDAY1 : 4'd0;
      err_q  <= ~(sec_ok & min_ok & hour_ok & day_ok);
    end else begin
      err_q  <= 1'b0;
      tick_q <= wrap;
      roll_q <= wrap & c_roll;
      if (wrap) begin
        pre   <= '0;
        sec0  <= n_sec0;
        sec1  <= n_sec1;
        min0  <= n_min0;
        min1  <= n_min1;
        hour0 <= n_hour0;
        hour1 <= n_hour1;
        day0  <= n_day0;
        day1  <= n_day1;
      end else begin
        pre <= pre + CNT_W'(1);
      end
    end
  end

  assign tk.SEC0     = sec0;
  assign tk.SEC1     = sec1;
  assign tk.MIN0     = min0;
  assign tk.MIN1     = min1;
  assign tk.HOUR0    = hour0;
  assign tk.HOUR1    = hour1;
  assign tk.DAY0     = day0;
  assign tk.DAY1     = day1;
  assign tk.TICK     = tick_q;
  assign tk.DAY_ROLL = roll_q;
  assign tk.LOAD_ERR = err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random set/run traffic
// against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int TD = 4;

  logic CLK;
  logic RST;

  time_keeper_if tk ();

  time_keeper #(
    .TICK_DIV(TD),
    .CNT_W   (3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .tk (tk)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int md, mh, mm, ms, ph;
  bit etick, eroll, eerr;
  int rolls_seen;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit ok(
    input int t, input int o,
    input int lo, input int hi
  );
    return t < 10 && o < 10
        && t * 10 + o >= lo && t * 10 + o <= hi;
  endfunction

  function automatic int val(input int t, input int o);
    return t * 10 + o;
  endfunction

  // Reference: whole time advanced as seconds of day plus day number
  task automatic model_edge();
    int t;
    bit bs, bm, bh, bd;
    etick = 0;
    eroll = 0;
    if (RST) begin
      md = 1; mh = 0; mm = 0; ms = 0;
      ph = 0; eerr = 0;
    end else if (tk.SET) begin
      ph = 0;
      bs = ok(tk.SSEC1, tk.SSEC0, 0, 59);
      bm = ok(tk.SMIN1, tk.SMIN0, 0, 59);
      bh = ok(tk.SHOUR1, tk.SHOUR0, 0, 23);
      bd = ok(tk.SDAY1, tk.SDAY0, 1, 31);
      ms = bs ? val(tk.SSEC1, tk.SSEC0) : 0;
      mm = bm ? val(tk.SMIN1, tk.SMIN0) : 0;
      mh = bh ? val(tk.SHOUR1, tk.SHOUR0) : 0;
      md = bd ? val(tk.SDAY1, tk.SDAY0) : 1;
      eerr = !(bs && bm && bh && bd);
    end else begin
      eerr = 0;
      ph++;
      if (ph == TD) begin
        ph = 0;
        etick = 1;
        t = (mh * 60 + mm) * 60 + ms + 1;
        if (t == 86400) begin
          t = 0;
          md = md % 31 + 1;
          eroll = (md == 1);
        end
        mh = t / 3600;
        mm = (t / 60) % 60;
        ms = t % 60;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("time",
        {tk.DAY1, tk.DAY0, tk.HOUR1, tk.HOUR0,
         tk.MIN1, tk.MIN0, tk.SEC1, tk.SEC0},
        {bcd(md), bcd(mh), bcd(mm), bcd(ms)});
    chk("tick", 32'(tk.TICK), 32'(etick));
    chk("roll", 32'(tk.DAY_ROLL), 32'(eroll));
    chk("lerr", 32'(tk.LOAD_ERR), 32'(eerr));
    if (tk.DAY_ROLL === 1'b1) rolls_seen++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(
    input int d1, input int d0,
    input int h1, input int h0,
    input int m1, input int m0,
    input int s1, input int s0
  );
    tk.SDAY1  = 4'(d1);
    tk.SDAY0  = 4'(d0);
    tk.SHOUR1 = 4'(h1);
    tk.SHOUR0 = 4'(h0);
    tk.SMIN1  = 4'(m1);
    tk.SMIN0  = 4'(m0);
    tk.SSEC1  = 4'(s1);
    tk.SSEC0  = 4'(s0);
  endtask

  function automatic int rdig(input int hi);
    if ($urandom_range(0, 9) == 0)
      return int'($urandom_range(0, 15));
    return int'($urandom_range(0, hi));
  endfunction

  initial begin
    RST = 1'b1;
    tk.SET = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    rolls_seen = 0;
    md = 1; mh = 0; mm = 0; ms = 0; ph = 0;

    // 1) reset then free run
    cyc(3);
    chk("rst_day", 32'({tk.DAY1, tk.DAY0}), 32'h01);
    RST = 1'b0;
    cyc(14);
    chk("run_sec", 32'({tk.SEC1, tk.SEC0}), 32'h03);

    // 2) load 01 23:59:58, two ticks to next day
    tk.SET = 1'b1;
    put(0, 1, 2, 3, 5, 9, 5, 8);
    cyc(2);
    tk.SET = 1'b0;
    rolls_seen = 0;
    cyc(2 * TD);
    chk("day2", 32'({tk.DAY1, tk.DAY0, tk.HOUR1,
        tk.HOUR0, tk.MIN1, tk.MIN0, tk.SEC1, tk.SEC0}),
        32'h02000000);
    chk("noroll", 32'(rolls_seen), 32'd0);

    // 3) load 31 23:59:59, wrap to day 01
    tk.SET = 1'b1;
    put(3, 1, 2, 3, 5, 9, 5, 9);
    cyc(2);
    tk.SET = 1'b0;
    cyc(TD);
    chk("wrap_roll", 32'(tk.DAY_ROLL), 32'd1);
    chk("wrap_day", 32'({tk.DAY1, tk.DAY0}), 32'h01);
    cyc(3);

    // 4) invalid hour then valid hour
    tk.SET = 1'b1;
    put(0, 5, 2, 4, 3, 0, 0, 0);
    cyc(1);
    chk("err_hi", 32'(tk.LOAD_ERR), 32'd1);
    chk("err_hr", 32'({tk.HOUR1, tk.HOUR0}), 32'h00);
    chk("err_min", 32'({tk.MIN1, tk.MIN0}), 32'h30);
    put(0, 5, 1, 2, 3, 0, 0, 0);
    cyc(1);
    chk("err_lo", 32'(tk.LOAD_ERR), 32'd0);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1);
    chk("day00", 32'({tk.LOAD_ERR, tk.DAY1, tk.DAY0}),
        32'h101);
    tk.SET = 1'b0;
    cyc(1);

    // 5) SET pulse at prescaler count 2
    for (int i = 0; i < 8 && ph != 2; i++) cyc(1);
    tk.SET = 1'b1;
    put(1, 0, 1, 0, 1, 0, 1, 0);
    cyc(3);
    tk.SET = 1'b0;
    cyc(TD - 1);
    chk("pre_tick", 32'(tk.TICK), 32'd0);
    cyc(1);
    chk("post_tick", 32'(tk.TICK), 32'd1);

    // 6) reset wins over SET
    tk.SET = 1'b1;
    put(1, 5, 0, 3, 0, 3, 0, 3);
    cyc(2);
    RST = 1'b1;
    put(9, 9, 9, 9, 9, 9, 9, 9);
    cyc(1);
    chk("rst_set", 32'({tk.LOAD_ERR, tk.DAY1, tk.DAY0,
        tk.HOUR1, tk.HOUR0, tk.MIN1, tk.MIN0,
        tk.SEC1, tk.SEC0}), 32'h001000000);
    RST = 1'b0;
    tk.SET = 1'b0;

    // random set/run traffic, starting near rollovers
    for (int k = 0; k < 150; k++) begin
      tk.SET = 1'b1;
      put(rdig(3), rdig(9), rdig(2), rdig(9),
          5, rdig(9), 5, rdig(9));
      if ($urandom_range(0, 3) == 0)
        put(rdig(3), rdig(9), rdig(2), rdig(9),
            rdig(5), rdig(9), rdig(5), rdig(9));
      cyc(int'($urandom_range(1, 3)));
      tk.SET = 1'b0;
      if ($urandom_range(0, 19) == 0) RST = 1'b1;
      cyc(1);
      RST = 1'b0;
      cyc(int'($urandom_range(1, 40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
